// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, csr field positions
// and the data-length decode used by the serializer and the baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int CSR_LEN_LSB  = 0;
  localparam int CSR_LEN_MSB  = 1;
  localparam int CSR_PAR_EN   = 2;
  localparam int CSR_PAR_ODD  = 3;
  localparam int CSR_STOP2    = 4;
  localparam int CSR_BAUD_LSB = 7;
  localparam int CSR_BAUD_MSB = 26;
  localparam int CSR_CFG_W    = 5;

  // 00..11 encodes 5..8 data bits.
  function automatic logic [3:0] data_len(input logic [1:0] len_code);
    logic [3:0] len;
    case (len_code)
      2'b00:   len = 4'd5;
      2'b01:   len = 4'd6;
      2'b10:   len = 4'd7;
      2'b11:   len = 4'd8;
      default: len = 4'd8;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding register feeding a tick-paced
// shift FSM that emits start, 5-8 LSB-first data bits, optional parity, 1-2 stops.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int   DATA_MAX   = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         csr,
  input  logic                tick,
  input  logic [DATA_MAX-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx,
  output logic                busy
);

  uart_tx_state_t        r_state;
  uart_tx_state_t        w_state_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  r_hold_empty;
  logic [DATA_MAX-1:0]   r_hold_data;
  logic [CSR_CFG_W-1:0]  r_hold_cfg;
  logic [DATA_MAX-1:0]   r_shift;
  logic [DATA_MAX-1:0]   w_shift_nxt;
  logic [1:0]            r_cfg_len;
  logic                  r_cfg_par_en;
  logic                  r_cfg_stop2;
  logic                  r_par;
  logic [3:0]            r_bit_cnt;
  logic [3:0]            w_bit_cnt_nxt;
  logic                  r_stop_cnt;
  logic                  w_stop_cnt_nxt;
  logic                  w_load;
  logic                  w_accept;
  logic [3:0]            w_cur_len;
  logic [3:0]            w_hold_len;
  logic [DATA_MAX-1:0]   w_hold_masked;
  logic                  w_hold_par;
  logic                  w_unused_csr;

  assign w_accept     = tx_valid & r_hold_empty;
  assign w_cur_len    = data_len(r_cfg_len);
  assign w_unused_csr = ^csr[31:CSR_CFG_W];

  assign tx_ready = r_hold_empty;
  assign tx       = r_tx;
  assign busy     = r_busy;

  // Parity of the queued byte, computed over the configured data bits only.
  always_comb begin
    w_hold_masked = {DATA_MAX{1'b0}};
    w_hold_len    = data_len(r_hold_cfg[CSR_LEN_MSB:CSR_LEN_LSB]);
    for (int i = 0; i < DATA_MAX; i++) begin
      w_hold_masked[i] = r_hold_data[i] & (i < int'(w_hold_len));
    end
    w_hold_par = (^w_hold_masked) ^ r_hold_cfg[CSR_PAR_ODD];
  end

  // Next-state and next-line-level logic; nothing advances without a tick.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_nxt       = r_tx;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_load         = 1'b0;
    case (r_state)
      IDLE: begin
        if (tick && !r_hold_empty) begin
          w_load        = 1'b1;
          w_tx_nxt      = 1'b0;
          w_shift_nxt   = r_hold_data;
          w_bit_cnt_nxt = 4'd0;
          w_state_nxt   = START;
        end else begin
          w_tx_nxt      = IDLE_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[DATA_MAX-1:1]};
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = DATA;
        end else begin
          w_state_nxt   = START;
        end
      end
      DATA: begin
        if (!tick) begin
          w_state_nxt    = DATA;
        end else if (r_bit_cnt < w_cur_len) begin
          w_tx_nxt       = r_shift[0];
          w_shift_nxt    = {1'b0, r_shift[DATA_MAX-1:1]};
          w_bit_cnt_nxt  = r_bit_cnt + 4'd1;
        end else if (r_cfg_par_en) begin
          w_tx_nxt       = r_par;
          w_state_nxt    = PARITY;
        end else begin
          w_tx_nxt       = IDLE_LEVEL;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = STOP;
        end
      end
      PARITY: begin
        if (tick) begin
          w_tx_nxt       = IDLE_LEVEL;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = STOP;
        end else begin
          w_state_nxt    = PARITY;
        end
      end
      STOP: begin
        if (!tick) begin
          w_state_nxt    = STOP;
        end else if (r_cfg_stop2 && !r_stop_cnt) begin
          w_stop_cnt_nxt = 1'b1;
        end else if (!r_hold_empty) begin
          // Chain straight into the next frame so there is no idle gap.
          w_load         = 1'b1;
          w_tx_nxt       = 1'b0;
          w_shift_nxt    = r_hold_data;
          w_bit_cnt_nxt  = 4'd0;
          w_state_nxt    = START;
        end else begin
          w_tx_nxt       = IDLE_LEVEL;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_tx_nxt    = IDLE_LEVEL;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM, line and shift state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_shift    <= {DATA_MAX{1'b0}};
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
    end
  end

  // Holding register: filled on handshake, drained when a frame is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_empty <= 1'b1;
      r_hold_data  <= {DATA_MAX{1'b0}};
      r_hold_cfg   <= {CSR_CFG_W{1'b0}};
    end else if (w_accept) begin
      r_hold_empty <= 1'b0;
      r_hold_data  <= tx_data;
      r_hold_cfg   <= csr[CSR_CFG_W-1:0];
    end else if (w_load) begin
      r_hold_empty <= 1'b1;
    end else begin
      r_hold_empty <= r_hold_empty;
    end
  end

  // Frame format latched with the byte so csr changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_len    <= 2'b00;
      r_cfg_par_en <= 1'b0;
      r_cfg_stop2  <= 1'b0;
      r_par        <= 1'b0;
    end else if (w_load) begin
      r_cfg_len    <= r_hold_cfg[CSR_LEN_MSB:CSR_LEN_LSB];
      r_cfg_par_en <= r_hold_cfg[CSR_PAR_EN];
      r_cfg_stop2  <= r_hold_cfg[CSR_STOP2];
      r_par        <= w_hold_par;
    end else begin
      r_cfg_len    <= r_cfg_len;
      r_cfg_par_en <= r_cfg_par_en;
      r_cfg_stop2  <= r_cfg_stop2;
      r_par        <= r_par;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: expected line bits are queued at
// accept time and a tick-driven monitor compares them against tx.
module tb_uart_tx_serializer;

  logic        clk;
  logic        rst;
  logic [31:0] csr;
  logic        tick;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   runs[$];
  int   run_len = 0;
  int   tcnt = 0;
  logic mon_tick;

  uart_tx_serializer #(.DATA_MAX(8), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .csr(csr), .tick(tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % 4;
      tick = (tcnt == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every tick edge after which busy is high carries exactly one frame bit.
  always @(posedge clk) begin
    mon_tick = tick;
    #1;
    if (rst) begin
      run_len = 0;
    end else if (mon_tick) begin
      if (busy) begin
        run_len++;
        if (exp_q.size() == 0) begin
          chk("exp_underflow", 32'd1, 32'd0);
        end else begin
          chk("tx_bit", tx, exp_q.pop_front());
        end
      end else begin
        if (run_len > 0) runs.push_back(run_len);
        run_len = 0;
        chk("idle_level", tx, 1'b1);
      end
    end
  end

  task automatic push_model(input logic [4:0] cfg, input logic [7:0] data);
    int len;
    int ones;
    bit pb;
    len = 5 + int'(cfg[1:0]);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (cfg[2]) begin
      pb = (ones % 2 == 1);
      if (cfg[3]) pb = !pb;
      exp_q.push_back(pb);
    end
    exp_q.push_back(1'b1);
    if (cfg[4]) exp_q.push_back(1'b1);
  endtask

  task automatic push_lit(input logic [11:0] vec, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(vec[i]);
  endtask

  task automatic offer(input logic [4:0] cfg, input logic [7:0] data, input int limit,
                       output bit accepted);
    logic [31:0] r32;
    @(negedge clk);
    r32 = $urandom;
    csr = {r32[31:5], cfg};
    tx_data = data;
    tx_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (tx_ready) begin
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        accepted = 1'b1;
        chk("ready_low_after_accept", tx_ready, 1'b0);
        return;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_busy_ready();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) begin
        chk("ready_after_start", tx_ready, 1'b1);
        return;
      end
    end
    chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_run(input string name, input int exp);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (runs.size() > 0) begin
        chk(name, runs.pop_front(), exp);
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit acc;
    logic [4:0] cfg;
    logic [7:0] d;
    logic [31:0] r32;
    int gap;
    bit done;

    rst = 1'b0; csr = 32'd0; tx_data = 8'd0; tx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 8N1 0x55
    offer(5'b00011, 8'h55, 50, acc);
    chk("accept_8n1", acc, 1'b1);
    push_lit(12'h2AA, 10);
    wait_busy_ready();
    wait_run("len_8n1", 10);

    // 7E1 0xC3, MSB ignored
    offer(5'b00110, 8'hC3, 50, acc);
    chk("accept_7e1", acc, 1'b1);
    push_lit(12'h386, 10);
    wait_busy_ready();
    wait_run("len_7e1", 10);

    // 5O2 0x1F
    offer(5'b11100, 8'h1F, 50, acc);
    chk("accept_5o2", acc, 1'b1);
    push_lit(12'h1BE, 9);
    wait_busy_ready();
    wait_run("len_5o2", 9);

    // Back-to-back frames with a stalled third offer
    offer(5'b00011, 8'hA5, 50, acc);
    chk("accept_b2b_1", acc, 1'b1);
    push_model(5'b00011, 8'hA5);
    offer(5'b00011, 8'h3C, 100, acc);
    chk("accept_b2b_2", acc, 1'b1);
    push_model(5'b00011, 8'h3C);
    offer(5'b00011, 8'h77, 20, acc);
    chk("third_offer_stall", acc, 1'b0);
    wait_run("len_b2b", 20);

    // csr change mid-frame must not affect the frame in flight
    offer(5'b00011, 8'h9B, 50, acc);
    chk("accept_iso_1", acc, 1'b1);
    push_model(5'b00011, 8'h9B);
    repeat (12) @(negedge clk);
    csr[1:0] = 2'b00;
    wait_run("len_iso_8", 10);
    offer(5'b00000, 8'hE6, 50, acc);
    chk("accept_iso_2", acc, 1'b1);
    push_model(5'b00000, 8'hE6);
    wait_run("len_iso_5", 7);

    // Randomized traffic; csr scrambled after each accept
    for (int it = 0; it < 40; it++) begin
      r32 = $urandom;
      cfg = r32[4:0];
      d = r32[15:8];
      offer(cfg, d, 300, acc);
      chk("rand_accept", acc, 1'b1);
      if (acc) push_model(cfg, d);
      csr = $urandom;
      gap = $urandom_range(0, 60);
      repeat (gap) @(negedge clk);
    end
    done = 1'b0;
    for (int k = 0; k < 800 && !done; k++) begin
      @(negedge clk);
      if (!busy && tx_ready) done = 1'b1;
    end
    chk("drain_idle", done, 1'b1);
    repeat (8) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    runs.delete();

    // Asynchronous reset in the middle of a data bit
    offer(5'b00011, 8'h5A, 50, acc);
    chk("accept_rst", acc, 1'b1);
    push_model(5'b00011, 8'h5A);
    wait_busy_ready();
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", tx_ready, 1'b1);
    exp_q.delete();
    runs.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      repeat (4) @(negedge clk);
      chk("post_rst_quiet_busy", busy, 1'b0);
      chk("post_rst_quiet_tx", tx, 1'b1);
    end
    chk("post_rst_no_runs", runs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
